lcd1602_bus_receiver: RTL and testbench
=======================================

// Module: lcd1602_bus_receiver
// PURPOSE
//  Listens on the HD44780-style 8-bit LCD bus (rs/rw/e/data) produced by the LCD controller and keeps a shadow copy
//  of the display: 80-byte DDRAM, address counter, display/entry/function flags. Sits beside the controller
//  (mirror to VGA/UART, self-check) or stands in as a synthesizable panel model in benches.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer depth for lcd_e/lcd_rs/lcd_rw/lcd_data (>=2)
//  LINE_LEN     40  DDRAM bytes per line (fixed HD44780 geometry; 2 lines -> 80 B)
//  VIS_COLS     16  visible columns presented on the read port
//  CLR_CYCLES   80  clk cycles busy during clear (one DDRAM write per cycle)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-low
//  lcd_e        in   1  bus enable; transaction latched on its falling edge
//  lcd_rs       in   1  0=instruction, 1=data
//  lcd_rw       in   1  0=write, 1=read (reads are not serviced)
//  lcd_data     in   8  bus data
//  rd_row       in   1  read-port line select
//  rd_col       in   4  read-port visible column 0..VIS_COLS-1
//  rd_data      out  8  char at (rd_row, rd_col) after display shift, 1-cycle latency
//  addr_cnt     out  7  DDRAM address counter (0x00-0x27, 0x40-0x67)
//  shift_ofs    out  6  display shift offset 0..39
//  disp_on, cur_on, blink_on  out 1 each  display-control flags
//  entry_inc, entry_shift     out 1 each  entry-mode flags
//  func_8bit, func_2line      out 1 each  function-set flags
//  busy         out  1  clear/home in progress
//  cmd_pulse    out  1  1-cycle pulse per executed instruction
//  char_pulse   out  1  1-cycle pulse per executed data write
//  rd_ignored   out  1  1-cycle pulse when an rw=1 transaction is dropped
//  overrun      out  1  1-cycle pulse when a transaction is dropped (pending slot full)
// BEHAVIOUR
//  - Reset: DDRAM not cleared; addr_cnt=0, shift_ofs=0, disp/cur/blink=0, entry_inc=1, entry_shift=0,
//    func_8bit=1, func_2line=1, busy=0, all pulses 0, rd_data=0x00, FSM=IDLE, pending empty.
//    Reset mid-clear aborts the clear; partially written DDRAM is left as is.
//  - Capture: all bus inputs go through SYNC_STAGES flops; sync'd E 1->0 latches {rs,rw,data} into the capture reg.
//    rw=1 -> rd_ignored pulse, nothing else happens.
//  - FSM IDLE->EXEC on capture (or pending valid); EXEC takes 1 cycle -> IDLE; clear: EXEC->CLEAR (CLR_CYCLES)->IDLE.
//  - Pending: capture while FSM!=IDLE goes to a 1-deep pending reg; capture while pending full -> overrun, dropped.
//    Capture and pending-pop in the same cycle: pop executes, new capture occupies the slot.
//  - Data write (rs=1): DDRAM[addr]<=data; addr steps +/-1 per entry_inc; if entry_shift, shift_ofs steps same
//    direction mod 40; char_pulse.
//  - Instruction decode by highest set bit:
//    b7 set DDRAM addr=data[6:0]; 0x28-0x3F -> 0x40, 0x68-0x7F -> 0x00
//    b6 set CGRAM addr: accepted, no state change (CGRAM not modelled)
//    b5 function set: func_8bit=d[4], func_2line=d[3]; bus is always decoded as 8-bit
//    b4 cursor/display shift: d[3]=1 shifts shift_ofs, else moves addr; d[2]=1 right(+1), else left(-1)
//    b3 display control: disp_on=d[2], cur_on=d[1], blink_on=d[0]
//    b2 entry mode: entry_inc=d[1], entry_shift=d[0]
//    b1 return home: addr=0, shift_ofs=0, busy for 1 cycle
//    b0 clear: addrs 0..79 linear written 0x20 over CLR_CYCLES, busy=1 throughout; then addr=0, shift_ofs=0,
//       entry_inc=1
//    0x00: no-op, still pulses cmd_pulse
//  - Address wrap: +1 at 0x27->0x40, 0x67->0x00; -1 at 0x00->0x67, 0x40->0x27. shift_ofs wraps 39<->0.
//  - Read port: linear idx = rd_row*40 + (rd_col+shift_ofs) mod 40; rd_data registered, 1-cycle latency;
//    DDRAM write and read to the same index in one cycle returns the old data.
// STRUCTURE
//  - Package lcd1602_pkg: instruction bit positions, CHAR_SPACE=8'h20, LINE2_BASE=7'h40, LINE_LEN, FSM state enum.
//  - Sub-module lcd1602_ddram: 80x8 simple dual-port RAM, 1 write port, 1 registered read port.
// TESTING
//  1 Reset, send 0x38,0x0C,0x06 -> func_8bit=1, func_2line=1, disp_on=1, cur_on=0, entry_inc=1, 3 cmd_pulses.
//  2 0x01 then "Azimut:" -> busy 80 cycles; row0 col0..6 = "Azimut:", col7..15 = 0x20, addr_cnt=0x07.
//  3 0xC0+10 then "45" -> DDRAM[0x4A]='4', [0x4B]='5'; rd_row=1, rd_col=10 -> '4' one cycle later.
//  4 addr 0x27, write 'X' -> addr_cnt=0x40; entry_inc=0 at 0x00, write 'Y' -> addr_cnt=0x67.
//  5 Two writes during clear -> first executes after clear; third during clear -> overrun, dropped.
//  6 rw=1 strobe -> rd_ignored, DDRAM/addr unchanged; reset asserted at clear cycle 30 -> busy=0, FSM IDLE.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared constants, transaction types and FSM states for the HD44780 bus receiver.
package lcd1602_pkg;
    localparam int         LINE_LEN   = 40;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;

    localparam int BIT_SET_DDRAM = 7;
    localparam int BIT_SET_CGRAM = 6;
    localparam int BIT_FUNC_SET  = 5;
    localparam int BIT_SHIFT     = 4;
    localparam int BIT_DISP_CTRL = 3;
    localparam int BIT_ENTRY     = 2;
    localparam int BIT_HOME      = 1;
    localparam int BIT_CLEAR     = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } bus_txn_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } cmd_t;

    // Address counter walks 0x00-0x27 then 0x40-0x67 and wraps between the two lines.
    function automatic logic [6:0] addr_step(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == LINE1_LAST)      nxt = LINE2_BASE;
            else if (addr == LINE2_LAST) nxt = 7'h00;
            else                         nxt = addr + 7'd1;
        end else begin
            if (addr == 7'h00)           nxt = LINE2_LAST;
            else if (addr == LINE2_BASE) nxt = LINE1_LAST;
            else                         nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

    function automatic logic [6:0] addr_fix(input logic [6:0] addr);
        logic [6:0] fixed;
        if (addr > LINE1_LAST && addr < LINE2_BASE) fixed = LINE2_BASE;
        else if (addr > LINE2_LAST)                 fixed = 7'h00;
        else                                        fixed = addr;
        return fixed;
    endfunction

    function automatic logic [6:0] addr_to_lin(input logic [6:0] addr);
        logic [6:0] lin;
        if (addr >= LINE2_BASE) lin = addr - LINE2_BASE + 7'(LINE_LEN);
        else                    lin = addr;
        return lin;
    endfunction
endpackage

// File: rtl/lcd1602_ddram.sv
// Simple dual-port display RAM: one write port, one registered read port (read-before-write).
module lcd1602_ddram #(
    parameter int DEPTH = 80,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // Contents survive reset on purpose, like the real panel.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata <= 8'h00;
        else        rdata <= mem[raddr];
    end
endmodule

// File: rtl/lcd1602_bus_receiver.sv
// Shadow model of an HD44780 panel driven over the 8-bit rs/rw/e bus: DDRAM, address counter and mode flags.
module lcd1602_bus_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int LINE_LEN    = 40,
    parameter int VIS_COLS    = 16,
    parameter int CLR_CYCLES  = 80
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        lcd_e,
    input  logic                        lcd_rs,
    input  logic                        lcd_rw,
    input  logic [7:0]                  lcd_data,
    input  logic                        rd_row,
    input  logic [$clog2(VIS_COLS)-1:0] rd_col,
    output logic [7:0]                  rd_data,
    output logic [6:0]                  addr_cnt,
    output logic [5:0]                  shift_ofs,
    output logic                        disp_on,
    output logic                        cur_on,
    output logic                        blink_on,
    output logic                        entry_inc,
    output logic                        entry_shift,
    output logic                        func_8bit,
    output logic                        func_2line,
    output logic                        busy,
    output logic                        cmd_pulse,
    output logic                        char_pulse,
    output logic                        rd_ignored,
    output logic                        overrun
);
    import lcd1602_pkg::*;

    localparam int BUS_W = 11;

    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic             e_sync, e_prev_q, e_fall;
    bus_txn_t         sync_txn, cap_q;
    logic             cap_v_q, cap_write;

    state_t     state_q, state_d;
    cmd_t       cur_q, cur_d, pend_q, pend_d;
    logic       pend_v_q, pend_v_d;
    logic [6:0] clr_cnt_q;
    logic       exec_char, exec_cmd, cmd_clear, cmd_home, clr_last;

    logic       mem_we;
    logic [6:0] mem_waddr, mem_raddr, col_sum, col_lin;
    logic [7:0] mem_wdata;

    function automatic logic [5:0] shift_step(input logic [5:0] ofs, input logic right);
        logic [5:0] nxt;
        if (right) nxt = (ofs == 6'(LINE_LEN - 1)) ? 6'd0 : ofs + 6'd1;
        else       nxt = (ofs == 6'd0) ? 6'(LINE_LEN - 1) : ofs - 6'd1;
        return nxt;
    endfunction

    assign e_sync   = sync_q[SYNC_STAGES-1][BUS_W-1];
    assign sync_txn = sync_q[SYNC_STAGES-1][BUS_W-2:0];
    assign e_fall   = e_prev_q && !e_sync;

    // Bus is asynchronous to clk; data is sampled on the synchronized E falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_prev_q <= 1'b0;
            cap_q    <= '0;
            cap_v_q  <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_prev_q <= e_sync;
            cap_v_q  <= e_fall;
            if (e_fall) cap_q <= sync_txn;
        end
    end

    assign cap_write  = cap_v_q && !cap_q.rw;
    assign rd_ignored = cap_v_q && cap_q.rw;

    assign exec_char = (state_q == ST_EXEC) && cur_q.rs;
    assign exec_cmd  = (state_q == ST_EXEC) && !cur_q.rs;
    assign cmd_clear = cur_q.data == (8'd1 << BIT_CLEAR);
    assign cmd_home  = (cur_q.data >> BIT_HOME) == 8'd1;
    assign clr_last  = (state_q == ST_CLEAR) && (clr_cnt_q == 7'(CLR_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            clr_cnt_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 7'd1 : 7'd0;
        end
    end

    // A pending entry always wins over a fresh capture, which then takes over the slot.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        overrun  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_v_q) begin
                    cur_d    = pend_q;
                    state_d  = ST_EXEC;
                    pend_v_d = cap_write;
                    if (cap_write) pend_d = '{rs: cap_q.rs, data: cap_q.data};
                end else if (cap_write) begin
                    cur_d   = '{rs: cap_q.rs, data: cap_q.data};
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = (exec_cmd && cmd_clear) ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: if (clr_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && cap_write) begin
            if (pend_v_q) begin
                overrun = 1'b1;
            end else begin
                pend_v_d = 1'b1;
                pend_d   = '{rs: cap_q.rs, data: cap_q.data};
            end
        end
    end

    // Instructions decode by their highest set bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt    <= 7'h00;
            shift_ofs   <= 6'd0;
            disp_on     <= 1'b0;
            cur_on      <= 1'b0;
            blink_on    <= 1'b0;
            entry_inc   <= 1'b1;
            entry_shift <= 1'b0;
            func_8bit   <= 1'b1;
            func_2line  <= 1'b1;
        end else if (clr_last) begin
            addr_cnt  <= 7'h00;
            shift_ofs <= 6'd0;
            entry_inc <= 1'b1;
        end else if (exec_char) begin
            addr_cnt <= addr_step(addr_cnt, entry_inc);
            if (entry_shift) shift_ofs <= shift_step(shift_ofs, entry_inc);
        end else if (exec_cmd) begin
            if (cur_q.data[BIT_SET_DDRAM]) begin
                addr_cnt <= addr_fix(cur_q.data[6:0]);
            end else if (cur_q.data[BIT_SET_CGRAM]) begin
                addr_cnt <= addr_cnt;
            end else if (cur_q.data[BIT_FUNC_SET]) begin
                func_8bit  <= cur_q.data[4];
                func_2line <= cur_q.data[3];
            end else if (cur_q.data[BIT_SHIFT]) begin
                if (cur_q.data[3]) shift_ofs <= shift_step(shift_ofs, cur_q.data[2]);
                else               addr_cnt  <= addr_step(addr_cnt, cur_q.data[2]);
            end else if (cur_q.data[BIT_DISP_CTRL]) begin
                disp_on  <= cur_q.data[2];
                cur_on   <= cur_q.data[1];
                blink_on <= cur_q.data[0];
            end else if (cur_q.data[BIT_ENTRY]) begin
                entry_inc   <= cur_q.data[1];
                entry_shift <= cur_q.data[0];
            end else if (cur_q.data[BIT_HOME]) begin
                addr_cnt  <= 7'h00;
                shift_ofs <= 6'd0;
            end
        end
    end

    assign busy       = (state_q == ST_CLEAR) || (exec_cmd && cmd_home);
    assign cmd_pulse  = exec_cmd;
    assign char_pulse = exec_char;

    assign mem_we    = exec_char || (state_q == ST_CLEAR);
    assign mem_waddr = (state_q == ST_CLEAR) ? clr_cnt_q : addr_to_lin(addr_cnt);
    assign mem_wdata = (state_q == ST_CLEAR) ? CHAR_SPACE : cur_q.data;

    // Visible column is rotated by the display shift within its 40-byte line.
    assign col_sum   = 7'(rd_col) + 7'(shift_ofs);
    assign col_lin   = (col_sum >= 7'(LINE_LEN)) ? col_sum - 7'(LINE_LEN) : col_sum;
    assign mem_raddr = rd_row ? col_lin + 7'(LINE_LEN) : col_lin;

    lcd1602_ddram #(
        .DEPTH (2 * LINE_LEN)
    ) u_ddram (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// Directed bench for lcd1602_bus_receiver: drives the LCD bus and checks flags, counters and the read port.
module tb_lcd1602_bus_receiver;
    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic       rd_row;
    logic [3:0] rd_col;
    logic [7:0] rd_data;
    logic [6:0] addr_cnt;
    logic [5:0] shift_ofs;
    logic       disp_on, cur_on, blink_on, entry_inc, entry_shift, func_8bit, func_2line;
    logic       busy, cmd_pulse, char_pulse, rd_ignored, overrun;

    int total = 0, bad = 0;
    int cmd_cnt = 0, char_cnt = 0, busy_cnt = 0, ign_cnt = 0, ovr_cnt = 0;
    int snap_a, snap_b;

    always #5 clk = ~clk;

    lcd1602_bus_receiver dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .addr_cnt(addr_cnt), .shift_ofs(shift_ofs), .disp_on(disp_on), .cur_on(cur_on),
        .blink_on(blink_on), .entry_inc(entry_inc), .entry_shift(entry_shift),
        .func_8bit(func_8bit), .func_2line(func_2line), .busy(busy), .cmd_pulse(cmd_pulse),
        .char_pulse(char_pulse), .rd_ignored(rd_ignored), .overrun(overrun)
    );

    always @(posedge clk) begin
        if (cmd_pulse)  cmd_cnt  <= cmd_cnt + 1;
        if (char_pulse) char_cnt <= char_cnt + 1;
        if (busy)       busy_cnt <= busy_cnt + 1;
        if (rd_ignored) ign_cnt  <= ign_cnt + 1;
        if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One full bus cycle, leaving enough idle time for the receiver to execute it.
    task automatic applyStimulus(input logic rs, input logic rw, input logic [7:0] data);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = data;
        @(negedge clk);
        lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic sendCmd(input logic [7:0] data);
        applyStimulus(1'b0, 1'b0, data);
    endtask

    task automatic sendChar(input logic [7:0] data);
        applyStimulus(1'b1, 1'b0, data);
    endtask

    task automatic readCell(input logic row, input logic [3:0] col, input string tag, input logic [7:0] exp);
        @(negedge clk);
        rd_row = row; rd_col = col;
        @(negedge clk);
        checkOutput(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    task automatic waitBusy(input logic level, input int budget);
        int n;
        n = 0;
        while (busy !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_busy", {31'h0, busy}, {31'h0, level});
    endtask

    initial begin
        string txt;
        reset = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
        rd_row = 1'b0; rd_col = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_addr", 32'(addr_cnt), 32'h00);
        checkOutput("rst_shift", 32'(shift_ofs), 32'h0);
        checkOutput("rst_disp", 32'(disp_on), 32'h0);
        checkOutput("rst_inc", 32'(entry_inc), 32'h1);
        checkOutput("rst_func", 32'({func_8bit, func_2line}), 32'h3);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        sendCmd(8'h20);
        checkOutput("func_4bit_1line", 32'({func_8bit, func_2line}), 32'h0);
        sendCmd(8'h38);
        checkOutput("func_8bit_2line", 32'({func_8bit, func_2line}), 32'h3);
        sendCmd(8'h0C);
        checkOutput("disp_ctrl", 32'({disp_on, cur_on, blink_on}), 32'h4);
        sendCmd(8'h06);
        checkOutput("entry_mode", 32'({entry_inc, entry_shift}), 32'h2);
        checkOutput("cmd_pulses", 32'(cmd_cnt), 32'd4);

        snap_a = busy_cnt;
        sendCmd(8'h01);
        waitBusy(1'b0, 200);
        checkOutput("clear_busy_len", 32'(busy_cnt - snap_a), 32'd80);
        txt = "Azimut:";
        for (int i = 0; i < txt.len(); i++) sendChar(txt[i]);
        checkOutput("azimut_addr", 32'(addr_cnt), 32'h07);
        for (int i = 0; i < 16; i++)
            readCell(1'b0, 4'(i), $sformatf("row0_col%0d", i), (i < txt.len()) ? txt[i] : 8'h20);

        sendCmd(8'hCA);
        sendChar("4");
        sendChar("5");
        checkOutput("line2_addr", 32'(addr_cnt), 32'h4C);
        readCell(1'b1, 4'd10, "row1_col10", "4");
        readCell(1'b1, 4'd11, "row1_col11", "5");

        sendCmd(8'hA7);
        sendChar("X");
        checkOutput("wrap_27_to_40", 32'(addr_cnt), 32'h40);
        sendCmd(8'hEA);
        checkOutput("set_addr_6A", 32'(addr_cnt), 32'h00);
        sendCmd(8'hB0);
        checkOutput("set_addr_30", 32'(addr_cnt), 32'h40);
        sendCmd(8'h80);
        sendCmd(8'h04);
        checkOutput("entry_dec", 32'(entry_inc), 32'h0);
        sendChar("Y");
        checkOutput("wrap_00_to_67", 32'(addr_cnt), 32'h67);
        readCell(1'b0, 4'd0, "row0_col0_Y", "Y");
        sendCmd(8'h18);
        checkOutput("shift_left_wrap", 32'(shift_ofs), 32'd39);
        readCell(1'b0, 4'd1, "shifted_col1", "Y");
        readCell(1'b0, 4'd0, "shifted_col0", "X");
        sendCmd(8'h1C);
        checkOutput("shift_right_wrap", 32'(shift_ofs), 32'd0);
        sendCmd(8'h10);
        checkOutput("cursor_left", 32'(addr_cnt), 32'h66);
        snap_a = busy_cnt;
        sendCmd(8'h02);
        checkOutput("home_addr", 32'(addr_cnt), 32'h00);
        checkOutput("home_busy_len", 32'(busy_cnt - snap_a), 32'd1);
        snap_a = cmd_cnt;
        sendCmd(8'h40);
        sendCmd(8'h00);
        checkOutput("cgram_nop_pulses", 32'(cmd_cnt - snap_a), 32'd2);
        checkOutput("cgram_nop_addr", 32'(addr_cnt), 32'h00);
        sendCmd(8'h07);
        sendChar("S");
        checkOutput("entry_shift_addr", 32'(addr_cnt), 32'h01);
        checkOutput("entry_shift_ofs", 32'(shift_ofs), 32'd1);
        sendCmd(8'h04);

        snap_a = ovr_cnt;
        snap_b = char_cnt;
        sendCmd(8'h01);
        sendChar("P");
        sendChar("Q");
        checkOutput("still_clearing", 32'(busy), 32'h1);
        waitBusy(1'b0, 200);
        repeat (10) @(negedge clk);
        checkOutput("overrun_pulse", 32'(ovr_cnt - snap_a), 32'd1);
        checkOutput("pending_char", 32'(char_cnt - snap_b), 32'd1);
        checkOutput("after_clear_addr", 32'(addr_cnt), 32'h01);
        checkOutput("after_clear_shift", 32'(shift_ofs), 32'd0);
        checkOutput("after_clear_inc", 32'(entry_inc), 32'h1);
        readCell(1'b0, 4'd0, "pending_P", "P");
        readCell(1'b0, 4'd1, "cleared_col1", 8'h20);
        readCell(1'b1, 4'd10, "cleared_row1", 8'h20);

        snap_a = ign_cnt;
        snap_b = char_cnt;
        applyStimulus(1'b1, 1'b1, "Z");
        checkOutput("rd_ignored", 32'(ign_cnt - snap_a), 32'd1);
        checkOutput("rd_no_char", 32'(char_cnt - snap_b), 32'd0);
        checkOutput("rd_addr_same", 32'(addr_cnt), 32'h01);
        readCell(1'b0, 4'd0, "rd_ddram_same", "P");

        sendCmd(8'hC0);
        sendChar("K");
        sendCmd(8'h80);
        sendChar("M");
        sendCmd(8'h01);
        repeat (27) @(negedge clk);
        checkOutput("pre_abort_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_addr", 32'(addr_cnt), 32'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        readCell(1'b1, 4'd0, "abort_keeps_K", "K");
        readCell(1'b0, 4'd0, "abort_partial", 8'h20);
        sendChar("R");
        checkOutput("post_abort_addr", 32'(addr_cnt), 32'h01);
        readCell(1'b0, 4'd0, "post_abort_R", "R");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
